// File: rtl/ami_wcmd_split_if.sv
// rtl/ami_wcmd_split_if.sv - AW/B channel bundle between the write-command splitter and the AXI master
//
// Purpose: carries the user-side AXI write-address and write-response channels.
// Ports (signals):
//   usr_awid/usr_awaddr/usr_awlen/usr_awsize/usr_awburst : burst request fields
//   usr_awvalid/usr_awready                              : AW handshake
//   usr_bid/usr_bresp/usr_bvalid/usr_bready              : write response channel
// Modports: master = splitter side (drives AW, accepts B), slave = AXI master side.
interface ami_wcmd_split_if #(
  parameter int AXI_AW = 32,
  parameter int AXI_IW = 8,
  parameter int AXI_LW = 8,
  parameter int AXI_SW = 3
);
  logic [AXI_IW-1:0] usr_awid;
  logic [AXI_AW-1:0] usr_awaddr;
  logic [AXI_LW-1:0] usr_awlen;
  logic [AXI_SW-1:0] usr_awsize;
  logic [1:0]        usr_awburst;
  logic              usr_awvalid;
  logic              usr_awready;
  logic [AXI_IW-1:0] usr_bid;
  logic [1:0]        usr_bresp;
  logic              usr_bvalid;
  logic              usr_bready;

  modport master (
    output usr_awid, usr_awaddr, usr_awlen, usr_awsize, usr_awburst, usr_awvalid,
    input  usr_awready,
    input  usr_bid, usr_bresp, usr_bvalid,
    output usr_bready
  );

  modport slave (
    input  usr_awid, usr_awaddr, usr_awlen, usr_awsize, usr_awburst, usr_awvalid,
    output usr_awready,
    output usr_bid, usr_bresp, usr_bvalid,
    input  usr_bready
  );
endinterface

// File: rtl/ami_wcmd_split.sv
// rtl/ami_wcmd_split.sv - splits one write command into 4 KB-safe INCR bursts and aggregates B responses
//
// Purpose: accepts a (start address, beat count) command, issues INCR bursts capped at
// MAX_BEATS and at the next 4 KB boundary, keeps at most MAX_OD bursts outstanding,
// and reports a single completion with an OR of all B error responses.
// Ports:
//   usr_clk, usr_reset_n         : clock, asynchronous active-low reset
//   cmd_id/cmd_addr/cmd_beats    : command fields, cmd_valid/cmd_ready handshake
//   axi (master modport)         : usr_aw* request channel and usr_b* response channel
//   done_valid/done_err          : one-cycle completion pulse and aggregated error
//   busy                         : high whenever the FSM is not idle
module ami_wcmd_split #(
  parameter int AXI_DW    = 128,
  parameter int AXI_AW    = 32,
  parameter int AXI_IW    = 8,
  parameter int AXI_LW    = 8,
  parameter int AXI_SW    = 3,
  parameter int MAX_BEATS = 256,
  parameter int MAX_OD    = 4,
  parameter int CNTW      = 24
) (
  input  logic                usr_clk,
  input  logic                usr_reset_n,
  input  logic [AXI_IW-1:0]   cmd_id,
  input  logic [AXI_AW-1:0]   cmd_addr,
  input  logic [CNTW-1:0]     cmd_beats,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  ami_wcmd_split_if.master    axi,
  output logic                done_valid,
  output logic                done_err,
  output logic                busy
);

  localparam int BYTES = AXI_DW / 8;
  localparam int SIZE  = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_B, DONE} state_t;

  state_t            state_q, state_d;
  logic [AXI_IW-1:0] id_q;
  logic [AXI_AW-1:0] addr_q;
  logic [AXI_LW-1:0] len_q;
  logic [AXI_SW-1:0] size_q;
  logic [CNTW-1:0]   rem_q;
  logic [CNTW-1:0]   issued_q;
  logic [CNTW-1:0]   received_q;
  logic              err_q;

  // Beats allowed from an address: bounded by what remains, MAX_BEATS and the
  // distance to the next 4 KB page. The page term uses 13 bits so a page-aligned
  // address yields the full 4096/BYTES.
  function automatic logic [CNTW-1:0] burst_beats(input logic [11:0] lo, input logic [CNTW-1:0] rem);
    logic [12:0]     room;
    logic [CNTW-1:0] cap;
    room = (13'd4096 - {1'b0, lo}) >> SIZE;
    cap  = CNTW'(room);
    if (cap > CNTW'(MAX_BEATS)) cap = CNTW'(MAX_BEATS);
    return (rem < cap) ? rem : cap;
  endfunction

  function automatic logic [AXI_LW-1:0] to_len(input logic [CNTW-1:0] beats);
    return AXI_LW'(beats - CNTW'(1));
  endfunction

  logic              aw_fire, b_fire, od_ok;
  logic [CNTW-1:0]   cur_beats, next_rem, next_beats, first_beats;
  logic [AXI_AW-1:0] next_addr, cmd_aligned;
  logic              unused_bid;

  assign aw_fire     = axi.usr_awvalid & axi.usr_awready;
  assign b_fire      = axi.usr_bvalid & axi.usr_bready;
  // Registered counts only, so an AW and a B in the same cycle can never push
  // the outstanding count past MAX_OD.
  assign od_ok       = (issued_q - received_q) < CNTW'(MAX_OD);
  assign cur_beats   = CNTW'(len_q) + CNTW'(1);
  assign next_addr   = addr_q + (AXI_AW'(cur_beats) << SIZE);
  assign next_rem    = rem_q - cur_beats;
  assign next_beats  = burst_beats(next_addr[11:0], next_rem);
  assign cmd_aligned = cmd_addr & ~AXI_AW'(BYTES - 1);
  assign first_beats = burst_beats(cmd_aligned[11:0], cmd_beats);
  assign unused_bid  = ^axi.usr_bid;

  // State register
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = (cmd_beats == '0) ? DONE : ISSUE;
      ISSUE:   if (aw_fire && next_rem == '0) state_d = WAIT_B;
      WAIT_B:  if (received_q == issued_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; usr_awvalid is decoded from the state register so reset drops it at once
  always_comb begin
    cmd_ready       = 1'b0;
    busy            = 1'b1;
    axi.usr_awvalid = 1'b0;
    axi.usr_bready  = 1'b0;
    done_valid      = 1'b0;
    done_err        = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ISSUE: begin
        axi.usr_awvalid = od_ok;
        axi.usr_bready  = 1'b1;
      end
      WAIT_B: axi.usr_bready = 1'b1;
      DONE: begin
        done_valid = 1'b1;
        done_err   = err_q;
      end
      default: busy = 1'b1;
    endcase
  end

  // Datapath: the next burst's length is computed at the handshake that retires
  // the current one, so the AW fields are already valid when usr_awvalid rises.
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      rem_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == IDLE && cmd_valid) begin
        id_q       <= cmd_id;
        addr_q     <= cmd_aligned;
        len_q      <= to_len(first_beats);
        size_q     <= AXI_SW'(SIZE);
        rem_q      <= cmd_beats;
        issued_q   <= '0;
        received_q <= '0;
        err_q      <= 1'b0;
      end
      if (aw_fire) begin
        addr_q   <= next_addr;
        rem_q    <= next_rem;
        len_q    <= to_len(next_beats);
        issued_q <= issued_q + CNTW'(1);
      end
      if (b_fire) begin
        received_q <= received_q + CNTW'(1);
        err_q      <= err_q | (axi.usr_bresp != 2'b00);
      end
    end
  end

  assign axi.usr_awid    = id_q;
  assign axi.usr_awaddr  = addr_q;
  assign axi.usr_awlen   = len_q;
  assign axi.usr_awsize  = size_q;
  assign axi.usr_awburst = 2'b01;

endmodule

// File: tb/tb_ami_wcmd_split.sv
// tb/tb_ami_wcmd_split.sv - self-checking bench for ami_wcmd_split with a burst-list reference model
module tb_ami_wcmd_split;
  localparam int AXI_DW = 128, AXI_AW = 32, AXI_IW = 8, AXI_LW = 8, AXI_SW = 3;
  localparam int MAX_BEATS = 256, MAX_OD = 4, CNTW = 24, BYTES = AXI_DW / 8;

  logic        usr_clk = 1'b0;
  logic        usr_reset_n = 1'b0;
  logic [7:0]  cmd_id = '0;
  logic [31:0] cmd_addr = '0;
  logic [23:0] cmd_beats = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready, done_valid, done_err, busy;

  ami_wcmd_split_if #(.AXI_AW(AXI_AW), .AXI_IW(AXI_IW), .AXI_LW(AXI_LW), .AXI_SW(AXI_SW)) axi ();

  ami_wcmd_split #(
    .AXI_DW(AXI_DW), .AXI_AW(AXI_AW), .AXI_IW(AXI_IW), .AXI_LW(AXI_LW), .AXI_SW(AXI_SW),
    .MAX_BEATS(MAX_BEATS), .MAX_OD(MAX_OD), .CNTW(CNTW)
  ) dut (
    .usr_clk(usr_clk), .usr_reset_n(usr_reset_n),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .axi(axi),
    .done_valid(done_valid), .done_err(done_err), .busy(busy)
  );

  always #5 usr_clk = ~usr_clk;

  int cyc = 0;
  always @(posedge usr_clk) cyc = cyc + 1;

  int n_checks = 0, n_pass = 0;
  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Controls written only by the main sequence
  bit rdy_rand = 1'b0;
  bit b_hold = 1'b0;
  int b_rel = 0;
  int err_abs = -1;

  // State written only by the monitor/responder process
  int b_pend = 0, b_idx = 0, b_rel_used = 0, od = 0, max_od = 0;
  int stall_bad = 0, done_n = 0, last_b_cyc = 0;
  bit b_taken = 1'b0, prev_stall = 1'b0;
  logic [52:0] prev_aw = '0;
  longint obs_addr[$];
  int obs_len[$], obs_size[$], obs_burst[$], obs_id[$];

  // Monitor at negedge, then drive awready / B channel just after posedge
  initial begin
    logic [52:0] cur_aw;
    axi.usr_awready = 1'b0;
    axi.usr_bvalid  = 1'b0;
    axi.usr_bresp   = 2'b00;
    axi.usr_bid     = '0;
    forever begin
      @(negedge usr_clk);
      if (usr_reset_n) begin
        cur_aw = {axi.usr_awid, axi.usr_awaddr, axi.usr_awlen, axi.usr_awsize, axi.usr_awburst};
        if (prev_stall && (!axi.usr_awvalid || cur_aw != prev_aw)) stall_bad++;
        prev_stall = axi.usr_awvalid && !axi.usr_awready;
        prev_aw = cur_aw;
        if (axi.usr_awvalid && axi.usr_awready) begin
          od++;
          b_pend++;
          obs_addr.push_back(longint'(axi.usr_awaddr));
          obs_len.push_back(int'(axi.usr_awlen));
          obs_size.push_back(int'(axi.usr_awsize));
          obs_burst.push_back(int'(axi.usr_awburst));
          obs_id.push_back(int'(axi.usr_awid));
        end
        if (axi.usr_bvalid && axi.usr_bready) begin
          od--;
          b_taken = 1'b1;
          last_b_cyc = cyc;
        end
        if (od > max_od) max_od = od;
        if (done_valid) done_n++;
      end else begin
        prev_stall = 1'b0;
        od = 0;
      end
      @(posedge usr_clk);
      #1;
      if (!usr_reset_n) begin
        axi.usr_bvalid = 1'b0;
        b_taken = 1'b0;
        b_pend = 0;
      end else begin
        if (b_taken) begin
          axi.usr_bvalid = 1'b0;
          b_taken = 1'b0;
        end
        if (!axi.usr_bvalid && b_pend > 0 && (!b_hold || b_rel_used < b_rel) &&
            $urandom_range(0, 3) != 0) begin
          axi.usr_bvalid = 1'b1;
          axi.usr_bresp  = (b_idx == err_abs) ? 2'b10 : 2'b00;
          axi.usr_bid    = 8'($urandom);
          b_idx++;
          b_pend--;
          if (b_hold) b_rel_used++;
        end
      end
      axi.usr_awready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Reference model: the whole command's burst list from plain page arithmetic
  longint m_addr[$];
  int m_len[$];
  int m_id, exp_nb, aw_base, done_base;
  bit exp_err;

  task automatic start_cmd(input int id, input longint addr, input int beats, input int e_at);
    longint a;
    int rem, room, b;
    bit ok;
    m_addr.delete();
    m_len.delete();
    a = addr - (addr % BYTES);
    rem = beats;
    while (rem > 0) begin
      room = int'((4096 - (a % 4096)) / BYTES);
      b = rem;
      if (b > MAX_BEATS) b = MAX_BEATS;
      if (b > room) b = room;
      m_addr.push_back(a);
      m_len.push_back(b - 1);
      a = (a + longint'(b) * BYTES) % 64'h1_0000_0000;
      rem = rem - b;
    end
    m_id = id;
    exp_nb = m_addr.size();
    exp_err = (e_at > 0 && e_at <= exp_nb);
    aw_base = obs_addr.size();
    done_base = done_n;
    err_abs = (e_at > 0) ? b_idx + e_at - 1 : -1;
    @(posedge usr_clk);
    #1;
    cmd_id = 8'(id);
    cmd_addr = addr[31:0];
    cmd_beats = 24'(beats);
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge usr_clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("cmd_accept", ok, 1);
    @(posedge usr_clk);
    #1;
    cmd_valid = 1'b0;
    cmd_id = 8'($urandom);
    cmd_addr = $urandom;
    cmd_beats = 24'($urandom);
  endtask

  task automatic finish_cmd(input bit chk_first);
    int lat, dcyc;
    bit seen;
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20000; i++) begin
      @(negedge usr_clk);
      if (i == 1 && chk_first && exp_nb > 0) begin
        check_eq("first_aw_lat", axi.usr_awvalid, 1);
        check_eq("busy_run", busy, 1);
        check_eq("ready_low_busy", cmd_ready, 0);
      end
      if (done_valid) begin
        seen = 1'b1;
        lat = i;
        break;
      end
    end
    check_eq("done_seen", seen, 1);
    if (!seen) return;
    dcyc = cyc;
    check_eq("done_err", done_err, exp_err);
    check_eq("ready_at_done", cmd_ready, 0);
    if (exp_nb > 0) check_eq("b_to_done_lat", dcyc - last_b_cyc, 2);
    else check_eq("zero_done_lat_le2", lat <= 2, 1);
    @(negedge usr_clk);
    check_eq("ready_after_done", cmd_ready, 1);
    check_eq("done_one_cycle", done_valid, 0);
    check_eq("idle_not_busy", busy, 0);
    repeat (2) @(negedge usr_clk);
    check_eq("done_pulses", done_n - done_base, 1);
    check_eq("aw_count", obs_addr.size() - aw_base, exp_nb);
    for (int k = 0; k < exp_nb && aw_base + k < obs_addr.size(); k++) begin
      check_eq("aw_addr", obs_addr[aw_base + k], m_addr[k]);
      check_eq("aw_len", obs_len[aw_base + k], m_len[k]);
      check_eq("aw_size", obs_size[aw_base + k], 4);
      check_eq("aw_burst", obs_burst[aw_base + k], 1);
      check_eq("aw_id", obs_id[aw_base + k], m_id & 8'hFF);
    end
  endtask

  function automatic longint obs_len_at(input int idx);
    return (idx < obs_len.size()) ? longint'(obs_len[idx]) : -1;
  endfunction

  function automatic longint obs_addr_at(input int idx);
    return (idx < obs_addr.size()) ? obs_addr[idx] : -1;
  endfunction

  task automatic check_reset(input string pfx);
    check_eq({pfx, "_cmd_ready"}, cmd_ready, 1);
    check_eq({pfx, "_awvalid"}, axi.usr_awvalid, 0);
    check_eq({pfx, "_bready"}, axi.usr_bready, 0);
    check_eq({pfx, "_done_valid"}, done_valid, 0);
    check_eq({pfx, "_done_err"}, done_err, 0);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_awaddr"}, axi.usr_awaddr, 0);
    check_eq({pfx, "_awlen"}, axi.usr_awlen, 0);
    check_eq({pfx, "_awsize"}, axi.usr_awsize, 0);
    check_eq({pfx, "_awid"}, axi.usr_awid, 0);
    check_eq({pfx, "_awburst"}, axi.usr_awburst, 1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int base;
    bit ok;
    usr_reset_n = 1'b0;
    repeat (3) @(posedge usr_clk);
    @(negedge usr_clk);
    check_reset("rst");
    usr_reset_n = 1'b1;

    // Single burst
    start_cmd(8'h11, 64'h1000, 16, 0);
    base = aw_base;
    finish_cmd(1'b1);
    check_eq("single_addr", obs_addr_at(base), 64'h1000);
    check_eq("single_len", obs_len_at(base), 15);

    // 4 KB crossing
    start_cmd(8'h22, 64'h0F80, 32, 0);
    base = aw_base;
    finish_cmd(1'b1);
    check_eq("xing_len0", obs_len_at(base), 7);
    check_eq("xing_addr1", obs_addr_at(base + 1), 64'h1000);
    check_eq("xing_len1", obs_len_at(base + 1), 23);

    // Multi-burst with random awready stalls
    rdy_rand = 1'b1;
    start_cmd(8'h33, 64'h0, 600, 0);
    base = aw_base;
    finish_cmd(1'b1);
    check_eq("long_len0", obs_len_at(base), 255);
    check_eq("long_addr1", obs_addr_at(base + 1), 64'h1000);
    check_eq("long_len1", obs_len_at(base + 1), 255);
    check_eq("long_addr2", obs_addr_at(base + 2), 64'h2000);
    check_eq("long_len2", obs_len_at(base + 2), 87);
    check_eq("stall_stable", stall_bad, 0);
    rdy_rand = 1'b0;

    // Outstanding limit with B withheld, then one released
    b_hold = 1'b1;
    start_cmd(8'h44, 64'h0, 2048, 0);
    repeat (40) @(negedge usr_clk);
    check_eq("od_limit_aw", obs_addr.size() - aw_base, MAX_OD);
    check_eq("od_awvalid_low", axi.usr_awvalid, 0);
    b_rel = b_rel + 1;
    repeat (40) @(negedge usr_clk);
    check_eq("od_release_aw", obs_addr.size() - aw_base, MAX_OD + 1);
    check_eq("od_release_awvalid_low", axi.usr_awvalid, 0);
    b_hold = 1'b0;
    finish_cmd(1'b0);

    // Error on the second B, then a clean command, then a zero-beat command
    start_cmd(8'h55, 64'h0, 1024, 2);
    finish_cmd(1'b1);
    start_cmd(8'h66, 64'h4000, 100, 0);
    finish_cmd(1'b1);
    start_cmd(8'h77, 64'h8000, 0, 0);
    finish_cmd(1'b1);

    // Address wrap at the top of the address space
    start_cmd(8'h88, 64'hFFFF_FF00, 40, 0);
    base = aw_base;
    finish_cmd(1'b1);
    check_eq("wrap_addr1", obs_addr_at(base + 1), 64'h0);

    // Reset while two bursts are outstanding
    b_hold = 1'b1;
    start_cmd(8'h99, 64'h0, 2048, 0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge usr_clk);
      if (obs_addr.size() - aw_base >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("mid_two_outstanding", ok, 1);
    @(posedge usr_clk);
    #2;
    usr_reset_n = 1'b0;
    #1;
    check_reset("mid");
    repeat (2) @(negedge usr_clk);
    usr_reset_n = 1'b1;
    b_hold = 1'b0;
    start_cmd(8'hAA, 64'h1000, 16, 0);
    finish_cmd(1'b1);

    // Randomized commands
    rdy_rand = 1'b1;
    for (int n = 0; n < 8; n++) begin
      longint ra;
      ra = longint'($urandom) & 64'hFFFF_FFF0;
      start_cmd(int'($urandom_range(0, 255)), ra, int'($urandom_range(1, 700)),
                int'($urandom_range(0, 3)));
      finish_cmd(1'b1);
    end
    rdy_rand = 1'b0;

    check_eq("aw_stable_all", stall_bad, 0);
    check_eq("max_outstanding", max_od, MAX_OD);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
